// File: rtl/urv_mem_pkg.sv
// Shared memory-block definitions for uRV RAMs, caches and TCMs.
// Controller states, log2 helper and parameter legality checks.
package urv_mem_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } ctrl_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit params_ok(
    input int dw,
    input int size,
    input int lat
  );
    bit ok;
    ok = (dw % 8 == 0) && (dw >= 8) && (dw <= 128);
    ok = ok && (size > 0) && ((size & (size - 1)) == 0);
    ok = ok && (size >= 2 * (dw / 8));
    ok = ok && (lat == 1 || lat == 2);
    return ok;
  endfunction

endpackage

// File: rtl/urv_dpram_out_pipe.sv
// Read-data/valid pipeline for one dpram port, 1 or 2 stages.
// Data registers only load on a valid beat, so outputs hold otherwise.
module urv_dpram_out_pipe
  import urv_mem_pkg::*;
#(
  parameter int g_width   = 32,
  parameter int g_latency = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               acc_i,
  input  logic [g_width-1:0] d_i,
  output logic [g_width-1:0] q_o,
  output logic               valid_o
);

  logic [g_width-1:0] d1;
  logic               v1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= acc_i;
      if (acc_i) d1 <= d_i;
    end
  end

  if (g_latency == 2) begin : g_two
    logic [g_width-1:0] d2;
    logic               v2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        d2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign q_o     = d2;
    assign valid_o = v2;
  end else begin : g_one
    assign q_o     = d1;
    assign valid_o = v1;
  end

endmodule

// File: rtl/urv_dpram.sv
// True dual-port byte-writable RAM for uRV, read-first on both ports.
// Holds the array, write arbitration, collision flag and clear engine.
module urv_dpram
  import urv_mem_pkg::*;
#(
  parameter int    g_data_width     = 32,
  parameter int    g_size           = 65536,
  parameter int    g_read_latency   = 1,
  parameter int    g_clear_on_reset = 0,
  parameter string g_init_file      = ""
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      ena_i,
  input  logic                      enb_i,
  input  logic                      wea_i,
  input  logic                      web_i,
  input  logic [31:0]               aa_i,
  input  logic [31:0]               ab_i,
  input  logic [g_data_width/8-1:0] bwea_i,
  input  logic [g_data_width/8-1:0] bweb_i,
  input  logic [g_data_width-1:0]   da_i,
  input  logic [g_data_width-1:0]   db_i,
  output logic [g_data_width-1:0]   qa_o,
  output logic [g_data_width-1:0]   qb_o,
  output logic                      valida_o,
  output logic                      validb_o,
  output logic                      ready_o,
  output logic                      collision_o
);

  localparam int NB  = g_data_width / 8;
  localparam int AW  = clog2(g_size);
  localparam int BW  = clog2(NB);
  localparam int WAW = AW - BW;
  localparam int NW  = g_size / NB;

  if (!params_ok(g_data_width, g_size, g_read_latency)) begin : g_bad
    $error("urv_dpram: illegal parameter set");
  end

  // File preload is owned by the simulation wrapper, not this model.
  if (g_init_file != "") begin : g_init
    $warning("urv_dpram: g_init_file ignored by this model");
  end

  logic [g_data_width-1:0] mem [NW];

  logic [31:0]    wa, wb;
  logic [WAW-1:0] ia, ib;
  logic           unused_addr;

  assign wa = aa_i >> BW;
  assign wb = ab_i >> BW;
  assign ia = wa[WAW-1:0];
  assign ib = wb[WAW-1:0];
  assign unused_addr = ^{wa[31:WAW], wb[31:WAW]};

  ctrl_st_e       st, st_nx;
  logic [WAW-1:0] clr_cnt;
  logic           clr_last;
  logic           ready_r, col_r;
  logic           acc_a, acc_b, wr_a, wr_b, same_word;

  assign acc_a     = ena_i & ready_r;
  assign acc_b     = enb_i & ready_r;
  assign wr_a      = acc_a & wea_i;
  assign wr_b      = acc_b & web_i;
  assign same_word = wr_a & wr_b & (ia == ib);
  assign clr_last  = (clr_cnt == WAW'(NW - 1));

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_RESET: st_nx = (g_clear_on_reset != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (clr_last) st_nx = ST_READY;
      ST_READY: st_nx = ST_READY;
      default:  st_nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st      <= ST_RESET;
      clr_cnt <= '0;
      ready_r <= 1'b0;
      col_r   <= 1'b0;
    end else begin
      st      <= st_nx;
      clr_cnt <= (st == ST_CLEAR) ? clr_cnt + WAW'(1) : '0;
      ready_r <= (st == ST_READY) | ((st == ST_CLEAR) & clr_last);
      col_r   <= same_word;
    end
  end

  // Array is never reset; port A is applied last so it wins shared bytes.
  always_ff @(posedge clk_i) begin
    if (st == ST_CLEAR) mem[clr_cnt] <= '0;
    for (int k = 0; k < NB; k++) begin
      if (wr_b && bweb_i[k]) mem[ib][8*k +: 8] <= db_i[8*k +: 8];
      if (wr_a && bwea_i[k]) mem[ia][8*k +: 8] <= da_i[8*k +: 8];
    end
  end

  urv_dpram_out_pipe #(
    .g_width  (g_data_width),
    .g_latency(g_read_latency)
  ) u_pipe_a (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .acc_i  (acc_a),
    .d_i    (mem[ia]),
    .q_o    (qa_o),
    .valid_o(valida_o)
  );

  urv_dpram_out_pipe #(
    .g_width  (g_data_width),
    .g_latency(g_read_latency)
  ) u_pipe_b (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .acc_i  (acc_b),
    .d_i    (mem[ib]),
    .q_o    (qb_o),
    .valid_o(validb_o)
  );

  assign ready_o     = ready_r;
  assign collision_o = col_r;

endmodule

// File: tb/tb_urv_dpram.sv
// Directed bench for urv_dpram in three configurations.
// u0: clear-on-reset, u1: 64-bit latency-2, u2: 64 KiB aliasing.
module tb_urv_dpram;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } p32_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] a;
    logic [7:0]  be;
    logic [63:0] d;
  } p64_t;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    bit          chk;
    logic [31:0] q;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p32_t pa0, pb0, pa2, pb2;
  p64_t pa1, pb1;

  logic [31:0] qa0, qb0, qa2, qb2;
  logic [63:0] qa1, qb1;
  logic va0, vb0, rdy0, col0;
  logic va1, vb1, rdy1, col1;
  logic va2, vb2, rdy2, col2;

  int n_chk = 0;
  int n_fail = 0;

  urv_dpram #(
    .g_data_width(32), .g_size(64),
    .g_read_latency(1), .g_clear_on_reset(1)
  ) u0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ena_i(pa0.en), .enb_i(pb0.en),
    .wea_i(pa0.we), .web_i(pb0.we),
    .aa_i(pa0.a), .ab_i(pb0.a),
    .bwea_i(pa0.be), .bweb_i(pb0.be),
    .da_i(pa0.d), .db_i(pb0.d),
    .qa_o(qa0), .qb_o(qb0),
    .valida_o(va0), .validb_o(vb0),
    .ready_o(rdy0), .collision_o(col0)
  );

  urv_dpram #(
    .g_data_width(64), .g_size(64),
    .g_read_latency(2), .g_clear_on_reset(0)
  ) u1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ena_i(pa1.en), .enb_i(pb1.en),
    .wea_i(pa1.we), .web_i(pb1.we),
    .aa_i(pa1.a), .ab_i(pb1.a),
    .bwea_i(pa1.be), .bweb_i(pb1.be),
    .da_i(pa1.d), .db_i(pb1.d),
    .qa_o(qa1), .qb_o(qb1),
    .valida_o(va1), .validb_o(vb1),
    .ready_o(rdy1), .collision_o(col1)
  );

  urv_dpram #(
    .g_data_width(32), .g_size(65536),
    .g_read_latency(1), .g_clear_on_reset(0)
  ) u2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ena_i(pa2.en), .enb_i(pb2.en),
    .wea_i(pa2.we), .web_i(pb2.we),
    .aa_i(pa2.a), .ab_i(pb2.a),
    .bwea_i(pa2.be), .bweb_i(pb2.be),
    .da_i(pa2.d), .db_i(pb2.d),
    .qa_o(qa2), .qb_o(qb2),
    .valida_o(va2), .validb_o(vb2),
    .ready_o(rdy2), .collision_o(col2)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t tv[12];
  logic [63:0] v64[3];

  initial begin
    pa0 = '0; pb0 = '0; pa1 = '0;
    pb1 = '0; pa2 = '0; pb2 = '0;

    tv[0]  = '{1, 32'h0000_0100, 4'hF, 32'h1234_5678, 0, 32'h0};
    tv[1]  = '{0, 32'h0000_0100, 4'h0, 32'h0,         1, 32'h1234_5678};
    tv[2]  = '{1, 32'h0000_0100, 4'h8, 32'hAA00_0000, 1, 32'h1234_5678};
    tv[3]  = '{0, 32'h0000_0100, 4'h0, 32'h0,         1, 32'hAA34_5678};
    tv[4]  = '{1, 32'h0001_0010, 4'hF, 32'hCAFE_F00D, 0, 32'h0};
    tv[5]  = '{0, 32'h0000_0010, 4'h0, 32'h0,         1, 32'hCAFE_F00D};
    tv[6]  = '{0, 32'h0002_0010, 4'h0, 32'h0,         1, 32'hCAFE_F00D};
    tv[7]  = '{1, 32'h0000_0013, 4'h1, 32'h0000_00EE, 1, 32'hCAFE_F00D};
    tv[8]  = '{0, 32'h0000_0010, 4'h0, 32'h0,         1, 32'hCAFE_F0EE};
    tv[9]  = '{1, 32'h0000_FFFC, 4'hF, 32'hA5A5_A5A5, 0, 32'h0};
    tv[10] = '{0, 32'h0001_FFFC, 4'h0, 32'h0,         1, 32'hA5A5_A5A5};
    tv[11] = '{0, 32'h0000_0100, 4'h0, 32'h0,         1, 32'hAA34_5678};

    v64[0] = 64'h0123_4567_89AB_CDEF;
    v64[1] = 64'h1111_2222_3333_4444;
    v64[2] = 64'hFEDC_BA98_7654_3210;

    // reset state
    repeat (3) tick;
    check("rst_qa", qa0, 0);
    check("rst_qb", qb0, 0);
    check("rst_va", va0, 0);
    check("rst_vb", vb0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_col", col0, 0);
    check("rst_clr_cnt", u0.clr_cnt, 0);
    check("rst_q1", qa1, 0);

    // ready timing after release
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick;
      check($sformatf("ready_clr_e%0d", e), rdy0, (e >= 17));
      if (e <= 3) begin
        check($sformatf("ready_noclr_e%0d", e), rdy2, (e >= 2));
        check($sformatf("ready_lat2_e%0d", e), rdy1, (e >= 2));
      end
    end

    // cleared contents, one-cycle latency
    for (int i = 0; i < 16; i++) begin
      pa0.en = 1; pa0.we = 0; pa0.a = 32'(i * 4);
      tick;
      check($sformatf("clr_rd%0d_v", i), va0, 1);
      check($sformatf("clr_rd%0d_q", i), qa0, 0);
    end
    pa0 = '0;
    tick;
    check("clr_rd_v_drop", va0, 0);

    // byte enables and cross-port read-first
    pa0 = '{1, 1, 32'h10, 4'hF, 32'hFFFF_FFFF};
    tick;
    pa0 = '{1, 1, 32'h10, 4'h5, 32'hDEAD_BEEF};
    pb0 = '{1, 0, 32'h10, 4'h0, 32'h0};
    tick;
    check("xport_rf_q", qb0, 32'hFFFF_FFFF);
    check("xport_rf_v", vb0, 1);
    check("xport_rf_col", col0, 0);
    pa0 = '0;
    tick;
    check("bwe_merge", qb0, 32'hFFAD_FFEF);

    // same-word collision, overlapping enables
    pa0 = '{1, 1, 32'h20, 4'h3, 32'h1111_1111};
    pb0 = '{1, 1, 32'h20, 4'h6, 32'h2222_2222};
    tick;
    check("col_pulse", col0, 1);
    pa0 = '0; pb0 = '0;
    tick;
    check("col_drop", col0, 0);
    pa0 = '{1, 0, 32'h20, 4'h0, 32'h0};
    tick;
    check("col_merge", qa0, 32'h0022_1111);

    // different words: no collision
    pa0 = '{1, 1, 32'h24, 4'hF, 32'h1};
    pb0 = '{1, 1, 32'h28, 4'hF, 32'h2};
    tick;
    check("nocol_diff", col0, 0);

    // same word via alias, disjoint enables
    pa0 = '{1, 1, 32'h2C, 4'h1, 32'h0000_0033};
    pb0 = '{1, 1, 32'h6C, 4'h8, 32'h4400_0000};
    tick;
    check("col_disjoint", col0, 1);
    pa0 = '0;
    pb0 = '{1, 0, 32'h2C, 4'h0, 32'h0};
    tick;
    check("col_disjoint_q", qb0, 32'h4400_0033);
    pb0 = '0;

    // table-driven, 64 KiB instance
    for (int i = 0; i < 12; i++) begin
      pa2 = '{1, tv[i].we, tv[i].a, tv[i].be, tv[i].d};
      tick;
      check($sformatf("tv%0d_v", i), va2, 1);
      if (tv[i].chk)
        check($sformatf("tv%0d_q", i), qa2, tv[i].q);
    end
    pa2 = '0;
    tick;
    check("hold_v", va2, 0);
    check("hold_q", qa2, 32'hAA34_5678);

    // latency 2, 64-bit, back-to-back
    for (int i = 0; i < 3; i++) begin
      pb1 = '{1, 1, 32'(i * 8), 8'hFF, v64[i]};
      tick;
    end
    pb1 = '0;
    for (int i = 0; i < 3; i++) begin
      pa1 = '{1, 0, 32'(i * 8), 8'h0, 64'h0};
      tick;
      check($sformatf("l2_v%0d", i), va1, (i >= 1));
      if (i >= 1)
        check($sformatf("l2_q%0d", i - 1), qa1, v64[i-1]);
    end
    pa1 = '0;
    tick;
    check("l2_v3", va1, 1);
    check("l2_q2", qa1, v64[2]);
    tick;
    check("l2_v_drop", va1, 0);
    check("l2_hold", qa1, v64[2]);

    // reset mid-clear restarts the clear
    pa0 = '{1, 1, 32'h3C, 4'hF, 32'h5A5A_5A5A};
    tick;
    pa0 = '0;
    rst_n = 1'b0;
    tick;
    check("rst2_ready", rdy0, 0);
    rst_n = 1'b1;
    repeat (8) tick;
    check("mid_clr_cnt", u0.clr_cnt, 7);
    rst_n = 1'b0;
    #1;
    check("abort_ready", rdy0, 0);
    tick;
    check("abort_cnt", u0.clr_cnt, 0);
    rst_n = 1'b1;
    pa0 = '{1, 0, 32'h0, 4'h0, 32'h0};
    for (int e = 1; e <= 17; e++) begin
      tick;
      check($sformatf("re_ready_e%0d", e), rdy0, (e >= 17));
      check($sformatf("re_noval_e%0d", e), va0, 0);
    end
    pa0 = '{1, 0, 32'h3C, 4'h0, 32'h0};
    tick;
    check("re_clr_v", va0, 1);
    check("re_clr_q", qa0, 0);
    pa0 = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
